// File: rtl/hamming_enc_seq.sv
// Sequencer that reads NUM_MSG 11-bit messages from data memory and writes back Hamming (16,11) SECDED words.
// Optional build macro HAM_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter output (cycle_cnt).
module hamming_enc_seq #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
`ifdef HAM_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CAP   = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] SRC     = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST     = ADDR_W'(DST_BASE);
  localparam logic [6:0]        LAST_IX = 7'(NUM_MSG - 1);

  state_t      state_reg, state_next;
  logic [6:0]  idx_reg, idx_next;
  logic [7:0]  lo_reg, lo_next;
  logic [15:0] word_reg, word_next;
  logic        done_reg, done_next;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] src_lo;
  logic [ADDR_W-1:0] dst_lo;

  // Word layout {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}; d[8:1] comes from the low byte.
  function automatic logic [15:0] encode(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  assign offset = ADDR_W'({idx_reg, 1'b0});
  assign src_lo = SRC + offset;
  assign dst_lo = DST + offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      lo_reg    <= '0;
      word_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      lo_reg    <= lo_next;
      word_reg  <= word_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    lo_next    = lo_reg;
    word_next  = word_reg;
    done_next  = done_reg;
    busy       = 1'b0;
    mem_addr   = '0;
    mem_wen    = 1'b0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          done_next  = 1'b0;
          idx_next   = '0;
          state_next = RD_LO;
        end
      end
      RD_LO: begin
        busy       = 1'b1;
        mem_addr   = src_lo;
        state_next = RD_HI;
      end
      RD_HI: begin
        busy       = 1'b1;
        lo_next    = mem_rdata;
        mem_addr   = src_lo + ADDR_W'(1);
        state_next = CAP;
      end
      CAP: begin
        // Only d[11:9] live in the high byte; the upper five bits are don't-care.
        busy       = 1'b1;
        word_next  = encode({mem_rdata[2:0], lo_reg});
        state_next = WR_LO;
      end
      WR_LO: begin
        busy       = 1'b1;
        mem_addr   = dst_lo;
        mem_wen    = 1'b1;
        mem_wdata  = word_reg[7:0];
        state_next = WR_HI;
      end
      WR_HI: begin
        busy      = 1'b1;
        mem_addr  = dst_lo + ADDR_W'(1);
        mem_wen   = 1'b1;
        mem_wdata = word_reg[15:8];
        if (idx_reg == LAST_IX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 7'd1;
          state_next = RD_LO;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign done = done_reg;

`ifdef HAM_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE && req) begin
      cnt_reg <= '0;
    end else if (busy && cnt_reg != 16'hFFFF) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign cycle_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Bench for hamming_enc_seq: behavioural memory, write-transaction scoreboard, table vectors and corner runs.
module tb_hamming_enc_seq;

  localparam int NUM_MSG = 15;
  localparam int SRC     = 0;
  localparam int DST     = 30;

  logic       clk;
  logic       reset;
  logic       req;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_wen;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef HAM_SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  hamming_enc_seq #(
    .NUM_MSG (NUM_MSG),
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .ADDR_W  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wen  (mem_wen),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef HAM_SEQ_CYCLE_CNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, read-before-write.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_wen) mem[mem_addr] = mem_wdata;
  end

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t        vecs [5];
  wr_t         sb [$];
  wr_t         mon_e;
  logic [7:0]  msg_lo [NUM_MSG];
  logic [7:0]  msg_hi [NUM_MSG];
  logic [15:0] exp_w  [NUM_MSG];
  int          checks;
  int          failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Positional Hamming reference: data at non-power-of-two positions, parity at 1,2,4,8, overall at 0.
  function automatic logic [15:0] ref_encode(input logic [7:0] lo, input logic [7:0] hi);
    logic [10:0] d;
    logic [15:0] w;
    logic        p;
    int          k;
    d = {hi[2:0], lo};
    w = '0;
    k = 0;
    for (int n = 1; n < 16; n++) begin
      if ((n & (n - 1)) != 0) begin
        w[n] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int n = 1; n < 16; n++) if ((n & (1 << b)) != 0) p = p ^ w[n];
      w[1 << b] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  always @(negedge clk) begin
    if (mem_wen) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
        $display("write addr=0x%02h data=0x%02h", mem_addr, mem_wdata);
      end
    end
  end

  // use_table=1 places the directed vectors in messages 0..4.
  task automatic load_msgs(input bit use_table);
    for (int i = 0; i < NUM_MSG; i++) begin
      if (use_table && i < 5) begin
        msg_lo[i] = vecs[i].lo;
        msg_hi[i] = vecs[i].hi;
        exp_w[i]  = vecs[i].exp;
      end else begin
        msg_lo[i] = 8'($urandom_range(0, 255));
        msg_hi[i] = 8'($urandom_range(0, 255));
        exp_w[i]  = ref_encode(msg_lo[i], msg_hi[i]);
      end
      mem[SRC + 2 * i]     = msg_lo[i];
      mem[SRC + 2 * i + 1] = msg_hi[i];
      sb.push_back('{addr: 8'(DST + 2 * i),     data: exp_w[i][7:0]});
      sb.push_back('{addr: 8'(DST + 2 * i + 1), data: exp_w[i][15:8]});
    end
  endtask

  // pulse_at / reset_at < 0 disables that event; counts are in cycles after the accepting edge.
  task automatic run_job(input string tag, input int pulse_at, input int reset_at);
    int n;
    bit got;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    got = 1'b0;
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (n == pulse_at)     req = 1'b1;
      if (n == pulse_at + 1) req = 1'b0;
      if (n == reset_at)     reset = 1'b1;
      if (reset_at >= 0 && n == reset_at + 1) begin
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_wen"},  32'(mem_wen), 32'd0);
`ifdef HAM_SEQ_CYCLE_CNT_EN
        check({tag, "_rst_cnt"},  32'(cycle_cnt), 32'd0);
`endif
        reset = 1'b0;
        sb.delete();
        $display("%s: reset applied at cycle %0d", tag, reset_at);
        return;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_done_cycle"}, 32'(n), 32'(5 * NUM_MSG + 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
`ifdef HAM_SEQ_CYCLE_CNT_EN
    check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'(5 * NUM_MSG));
`endif
    for (int i = 0; i < NUM_MSG; i++) begin
      check({tag, "_dst_lo"}, 32'(mem[DST + 2 * i]),     32'(exp_w[i][7:0]));
      check({tag, "_dst_hi"}, 32'(mem[DST + 2 * i + 1]), 32'(exp_w[i][15:8]));
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_holds"}, 32'(done), 32'd1);
    $display("%s: done after %0d cycles", tag, n);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    req      = 1'b0;
    reset    = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;

    vecs[0] = '{lo: 8'h00, hi: 8'h00, exp: 16'h0000};
    vecs[1] = '{lo: 8'hFF, hi: 8'h07, exp: 16'hFFFF};
    vecs[2] = '{lo: 8'h01, hi: 8'h00, exp: 16'h000F};
    vecs[3] = '{lo: 8'h00, hi: 8'h04, exp: 16'h8117};
    vecs[4] = '{lo: 8'h00, hi: 8'hFC, exp: 16'h8117};

    repeat (3) @(negedge clk);
    check("rst_done",  32'(done), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_wen",   32'(mem_wen), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
`ifdef HAM_SEQ_CYCLE_CNT_EN
    check("rst_cnt",   32'(cycle_cnt), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    load_msgs(1'b1);
    run_job("table", -1, -1);

    load_msgs(1'b0);
    run_job("busy_req", 10, -1);

    load_msgs(1'b0);
    run_job("mid_reset", -1, 20);

    load_msgs(1'b0);
    run_job("after_reset", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
